// File: rtl/dac_ctrl_pkg.sv
// Shared types and defaults for the DAC request scheduler.
// Holds the conversion FSM state encoding and default channel/code widths.
package dac_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold
  } state_e;

  localparam int unsigned DefNch  = 4;
  localparam int unsigned DefBits = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the lowest requesting index at or
// above ptr, wrapping modulo NCH.
module rr_arbiter #(
  parameter int unsigned NCH = 4
) (
  input  logic [NCH-1:0]         req,
  input  logic [$clog2(NCH)-1:0] ptr,
  output logic [NCH-1:0]         grant,
  output logic [$clog2(NCH)-1:0] idx,
  output logic                   valid
);

  localparam int unsigned IW = $clog2(NCH);
  localparam int N = int'(NCH);

  int k;

  // Scan from the far end down so the candidate nearest ptr wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    k     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % N;
      if (req[k]) begin
        valid = 1'b1;
        idx   = IW'(k);
      end
    end
    if (valid) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/dac_scheduler.sv
// Shares one DAC among NCH requesters: round-robin grant, then a
// setup / strobe / hold sequence around the DAC's rising-edge update.
module dac_scheduler
  import dac_ctrl_pkg::*;
#(
  parameter int unsigned NCH  = DefNch,
  parameter int unsigned BITS = DefBits
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         req,
  input  logic [NCH*BITS-1:0]    code,
  output logic [NCH-1:0]         ack,
  output logic [BITS-1:0]        dac_in,
  output logic                   dac_clk,
  output logic                   busy,
  output logic [$clog2(NCH)-1:0] last_ch
);

  localparam int unsigned IW = $clog2(NCH);

  state_e          state_q;
  logic [IW-1:0]   rr_ptr_q;
  logic [NCH-1:0]  gnt_q;
  logic [NCH-1:0]  arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_valid;
  logic [BITS-1:0] sel_code;

  rr_arbiter #(
    .NCH (NCH)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    sel_code = code[arb_idx*BITS +: BITS];
  end

  // Every output is a flop; req/code only matter on the IDLE grant edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      dac_in   <= '0;
      dac_clk  <= 1'b0;
      ack      <= '0;
      busy     <= 1'b0;
      last_ch  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arb_valid) begin
            state_q  <= StSetup;
            busy     <= 1'b1;
            gnt_q    <= arb_grant;
            dac_in   <= sel_code;
            last_ch  <= arb_idx;
            rr_ptr_q <= (arb_idx == IW'(NCH - 1)) ? '0 : arb_idx + 1'b1;
          end
        end
        StSetup: begin
          state_q <= StStrobe;
          dac_clk <= 1'b1;
          ack     <= gnt_q;
        end
        StStrobe: begin
          state_q <= StHold;
          dac_clk <= 1'b0;
          ack     <= '0;
        end
        StHold: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_scheduler.sv
// Scoreboard bench for dac_scheduler: a transaction-level model queues the
// expected grants; a negedge monitor pops them whenever ack appears.
module tb_dac_scheduler;

  localparam int NCH  = 4;
  localparam int BITS = 8;

  logic                clk   = 1'b0;
  logic                rst_n = 1'b0;
  logic [NCH-1:0]      req   = '0;
  logic [NCH*BITS-1:0] code  = '0;
  logic [NCH-1:0]      ack;
  logic [BITS-1:0]     dac_in;
  logic                dac_clk;
  logic                busy;
  logic [1:0]          last_ch;

  always #5 clk = ~clk;

  dac_scheduler #(
    .NCH  (NCH),
    .BITS (BITS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .code    (code),
    .ack     (ack),
    .dac_in  (dac_in),
    .dac_clk (dac_clk),
    .busy    (busy),
    .last_ch (last_ch)
  );

  typedef struct {
    int        ch;
    logic [7:0] code;
    int        edge_no;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         m_cnt    = 0;  // cycles left in the current conversion
  int         m_ptr    = 0;
  int         m_last   = 0;
  logic [7:0] m_dac    = '0;
  int         ack_log[$];
  int         ack_cyc[$];
  int         ack_cnt    = 0;
  int         strobe_cnt = 0;
  real        dac_out    = 0.0;
  logic [NCH-1:0] last_drop = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic check_real(input string name, input real act, input real exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %f expected %f", name, act, exp_v);
    end
  endtask

  // Reference model: one grant per conversion, 4 cycles each, round-robin pointer.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_cnt  = 0;
      m_ptr  = 0;
      m_dac  = '0;
      m_last = 0;
      exp_q.delete();
    end else if (m_cnt > 0) begin
      m_cnt--;
    end else if (req != '0) begin : grant_blk
      int ch;
      exp_t e;
      ch = -1;
      for (int i = 0; i < NCH; i++) begin
        if (ch < 0 && req[(m_ptr + i) % NCH]) ch = (m_ptr + i) % NCH;
      end
      m_dac     = code[ch*BITS +: BITS];
      m_last    = ch;
      m_ptr     = (ch + 1) % NCH;
      m_cnt     = 3;
      e.ch      = ch;
      e.code    = m_dac;
      e.edge_no = cyc + 1;
      exp_q.push_back(e);
    end
  end

  // DAC behaviour: updates only on a rising dac_clk.
  initial forever begin
    @(posedge dac_clk);
    strobe_cnt++;
    dac_out = real'(dac_in) / 256.0;
  end

  initial forever begin
    @(negedge clk);
    check("dac_clk", 32'(dac_clk), 32'(m_cnt == 2));
    check("busy", 32'(busy), 32'(m_cnt != 0));
    check("dac_in", 32'(dac_in), 32'(m_dac));
    check("last_ch", 32'(last_ch), 32'(m_last));
    if (ack != '0) begin
      int ch;
      ch = -1;
      for (int i = 0; i < NCH; i++) if (ack[i] && ch < 0) ch = i;
      ack_cnt++;
      ack_log.push_back(ch);
      ack_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'(ack), 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ack_onehot", 32'(ack), 32'(1) << e.ch);
        check("ack_code", 32'(dac_in), 32'(e.code));
        check("ack_edge", 32'(cyc), 32'(e.edge_no));
      end
    end else if (exp_q.size() > 0 && cyc > exp_q[0].edge_no) begin
      exp_t e;
      e = exp_q.pop_front();
      check("missing_ack", 32'(ack), 32'(1) << e.ch);
    end
  end

  // Advance one cycle; requesters drop req on the cycle their ack is seen.
  task automatic step();
    @(negedge clk);
    #1;
    last_drop = req & ack;
    req = req & ~ack;
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (m_cnt == 0 && req == '0 && exp_q.size() == 0) return;
      step();
    end
    n_checks++;
    n_fail++;
    $display("FAIL idle_timeout: still busy after %0d cycles", max_cyc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int g;
    int s0;
    int a0;
    int n2;

    step();
    step();
    step();
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_dac_in", 32'(dac_in), 32'h0);
    check("rst_dac_clk", 32'(dac_clk), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_last_ch", 32'(last_ch), 32'h0);
    rst_n = 1'b1;
    step();

    // Single request with full-scale code.
    ack_log.delete();
    ack_cyc.delete();
    code[0 +: 8] = 8'hFF;
    req = 4'b0001;
    g = cyc;
    wait_idle(20);
    check("single_cnt", 32'(ack_log.size()), 32'd1);
    if (ack_log.size() == 1) check("single_latency", 32'(ack_cyc[0]), 32'(g + 2));
    check_real("single_dac_out", dac_out, 0.99609375);

    // All four requesting from a fresh pointer.
    do_reset();
    ack_log.delete();
    ack_cyc.delete();
    for (int k = 0; k < NCH; k++) code[k*BITS +: BITS] = 8'($urandom);
    req = 4'b1111;
    wait_idle(40);
    check("rr_cnt", 32'(ack_log.size()), 32'd4);
    if (ack_log.size() == 4) begin
      for (int i = 0; i < 4; i++) check("rr_order", 32'(ack_log[i]), 32'(i));
      for (int i = 1; i < 4; i++) check("rr_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd4);
    end

    // Wrap-around: park pointer at 3, then 1001, then probe pointer with 0011.
    ack_log.delete();
    ack_cyc.delete();
    req = 4'b0100;
    wait_idle(20);
    req = 4'b1001;
    wait_idle(20);
    req = 4'b0011;
    wait_idle(20);
    check("wrap_cnt", 32'(ack_log.size()), 32'd5);
    if (ack_log.size() == 5) begin
      check("wrap_first", 32'(ack_log[1]), 32'd3);
      check("wrap_second", 32'(ack_log[2]), 32'd0);
      check("wrap_ptr_is_1", 32'(ack_log[3]), 32'd1);
    end

    // Code changes during SETUP are ignored.
    code[0 +: 8] = 8'h80;
    req = 4'b0001;
    step();
    code[0 +: 8] = 8'h01;
    wait_idle(20);
    check("midcode_dac_in", 32'(dac_in), 32'h80);
    check_real("midcode_dac_out", dac_out, 0.5);

    // Withdrawn request from channel 2 while busy.
    ack_log.delete();
    s0 = strobe_cnt;
    code[2*BITS +: BITS] = 8'h33;
    req = 4'b0001;
    step();
    req[2] = 1'b1;
    step();
    req[2] = 1'b0;
    wait_idle(20);
    n2 = 0;
    foreach (ack_log[i]) if (ack_log[i] == 2) n2++;
    check("withdraw_no_ack2", 32'(n2), 32'd0);
    check("withdraw_strobes", 32'(strobe_cnt - s0), 32'd1);

    // Reset while dac_clk is high.
    code[0 +: 8] = 8'h5A;
    req = 4'b0001;
    for (int i = 0; i < 10 && !dac_clk; i++) step();
    check("strobe_seen", 32'(dac_clk), 32'h1);
    s0 = strobe_cnt;
    rst_n = 1'b0;
    req = '0;
    step();
    check("rst_strobe_dac_clk", 32'(dac_clk), 32'h0);
    check("rst_strobe_ack", 32'(ack), 32'h0);
    check("rst_strobe_dac_in", 32'(dac_in), 32'h0);
    check("rst_strobe_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("rst_strobe_no_update", 32'(strobe_cnt - s0), 32'd0);

    // Reset during SETUP aborts without an ack.
    code[1*BITS +: BITS] = 8'h77;
    req = 4'b0010;
    step();
    check("setup_busy", 32'(busy), 32'h1);
    a0 = ack_cnt;
    s0 = strobe_cnt;
    rst_n = 1'b0;
    req = '0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("abort_no_ack", 32'(ack_cnt - a0), 32'd0);
    check("abort_no_strobe", 32'(strobe_cnt - s0), 32'd0);

    // Random traffic against the model.
    for (int t = 0; t < 400; t++) begin
      step();
      for (int k = 0; k < NCH; k++) begin
        if (!req[k]) begin
          if (!last_drop[k] && $urandom_range(0, 3) == 0) begin
            req[k] = 1'b1;
            code[k*BITS +: BITS] = 8'($urandom);
          end
        end else if ($urandom_range(0, 19) == 0) begin
          req[k] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          code[k*BITS +: BITS] = 8'($urandom);
        end
      end
    end
    req = '0;
    wait_idle(20);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
